// File: rtl/fitness_eval.sv
// fitness_eval: scores one individual's position trace for the maze GA.
// Tracks best Manhattan distance to the goal, first goal-reach step and
// death, then presents one registered score on a valid/ready output.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high. The producer holds valid and its data stable until
// that edge. The consumer may raise or lower ready at any time.
module fitness_eval #(
  parameter int COORD_W        = 4,
  parameter int GOAL_X         = 7,
  parameter int GOAL_Y         = 7,
  parameter int STEP_W         = 6,
  parameter int SCORE_W        = 10,
  parameter int ALIVE_BONUS_EN = 0,
  parameter int ALIVE_BONUS    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pos_valid,
  output logic               pos_ready,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               pos_alive,
  input  logic               pos_last,
  output logic               score_valid,
  input  logic               score_ready,
  output logic [SCORE_W-1:0] score,
  output logic               busy
);

  localparam logic [COORD_W:0]   DMAX      = (COORD_W+1)'(2 * ((1 << COORD_W) - 1));
  localparam logic [STEP_W-1:0]  STEP_MAX  = {STEP_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [COORD_W-1:0] GX        = COORD_W'(GOAL_X);
  localparam logic [COORD_W-1:0] GY        = COORD_W'(GOAL_Y);
  // Wide enough that base + bonus can never wrap before saturation.
  localparam int                 SUM_W     = SCORE_W + 32;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCORE, S_HOLD} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [COORD_W:0]   r_best;
  logic [STEP_W-1:0]  r_step;
  logic [STEP_W-1:0]  r_reach_step;
  logic               r_reached;
  logic               r_dead;
  logic               r_last_alive;
  logic [SCORE_W-1:0] r_score;

  logic               w_accept;
  logic [COORD_W-1:0] w_dx;
  logic [COORD_W-1:0] w_dy;
  logic [COORD_W:0]   w_dist;
  logic [SCORE_W-1:0] w_base;
  logic [SUM_W-1:0]   w_sum;
  logic [SCORE_W-1:0] w_score;

  assign pos_ready   = (r_state == S_ACCUM);
  assign score_valid = (r_state == S_HOLD);
  assign busy        = (r_state != S_IDLE);
  assign score       = r_score;
  assign w_accept    = pos_valid & pos_ready;

  // Absolute differences; coordinates on either side of the goal are legal.
  assign w_dx   = (pos_x >= GX) ? (pos_x - GX) : (GX - pos_x);
  assign w_dy   = (pos_y >= GY) ? (pos_y - GY) : (GY - pos_y);
  assign w_dist = {1'b0, w_dx} + {1'b0, w_dy};

  // Score: reaching the goal always beats any distance-only score.
  assign w_base  = r_reached
                 ? ((SCORE_W'(1) << (SCORE_W - 1)) + SCORE_W'(STEP_MAX - r_reach_step))
                 : SCORE_W'(DMAX - r_best);
  assign w_sum   = SUM_W'(w_base)
                 + (((ALIVE_BONUS_EN != 0) && r_last_alive) ? SUM_W'(ALIVE_BONUS) : '0);
  assign w_score = (w_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : w_sum[SCORE_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ACCUM;
      S_ACCUM: if (w_accept && pos_last) w_next = S_SCORE;
      S_SCORE: w_next = S_HOLD;
      S_HOLD:  if (score_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Trace accumulators and the registered score.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_best       <= '0;
      r_step       <= '0;
      r_reach_step <= '0;
      r_reached    <= 1'b0;
      r_dead       <= 1'b0;
      r_last_alive <= 1'b0;
      r_score      <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_best       <= DMAX;
        r_step       <= '0;
        r_reach_step <= '0;
        r_reached    <= 1'b0;
        r_dead       <= 1'b0;
        r_last_alive <= 1'b0;
      end
      if (w_accept) begin
        if (pos_alive && !r_dead) begin
          if (w_dist < r_best) r_best <= w_dist;
          if (w_dist == '0 && !r_reached) begin
            r_reached    <= 1'b1;
            r_reach_step <= r_step;
          end
        end
        if (!pos_alive) r_dead <= 1'b1;
        if (r_step != STEP_MAX) r_step <= r_step + 1'b1;
        if (pos_last) r_last_alive <= pos_alive & ~r_dead;
      end
      if (r_state == S_SCORE) r_score <= w_score;
    end
  end

endmodule

// File: tb/tb_fitness_eval.sv
// Bench for fitness_eval: two instances share one stimulus stream, one at
// default parameters and one narrow with the alive bonus enabled.
module tb_fitness_eval;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pos_valid = 1'b0;
  logic [3:0] pos_x = '0;
  logic [3:0] pos_y = '0;
  logic       pos_alive = 1'b0;
  logic       pos_last = 1'b0;
  logic       score_ready = 1'b1;

  logic       pos_ready_a, score_valid_a, busy_a;
  logic [9:0] score_a;
  logic       pos_ready_b, score_valid_b, busy_b;
  logic [6:0] score_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] exp_q_a[$];
  logic [6:0] exp_q_b[$];

  int tr_x[$];
  int tr_y[$];
  int tr_alive[$];

  fitness_eval dut_a (
    .clk(clk), .rst(rst), .start(start),
    .pos_valid(pos_valid), .pos_ready(pos_ready_a),
    .pos_x(pos_x), .pos_y(pos_y), .pos_alive(pos_alive), .pos_last(pos_last),
    .score_valid(score_valid_a), .score_ready(score_ready),
    .score(score_a), .busy(busy_a)
  );

  fitness_eval #(.STEP_W(5), .SCORE_W(7), .ALIVE_BONUS_EN(1)) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .pos_valid(pos_valid), .pos_ready(pos_ready_b),
    .pos_x(pos_x), .pos_y(pos_y), .pos_alive(pos_alive), .pos_last(pos_last),
    .score_valid(score_valid_b), .score_ready(score_ready),
    .score(score_b), .busy(busy_b)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference score for the trace held in tr_* (goal 7,7, 4-bit coords).
  function automatic int model(input int step_w, input int score_w, input int bonus_en);
    int best = 30;
    int reached = 0;
    int rs = 0;
    int dead = 0;
    int la = 0;
    int step = 0;
    int smax = (1 << step_w) - 1;
    int base;
    int d;
    int s;
    for (int i = 0; i < tr_x.size(); i++) begin
      if (tr_alive[i] != 0 && dead == 0) begin
        d = ((tr_x[i] > 7) ? tr_x[i] - 7 : 7 - tr_x[i]) + ((tr_y[i] > 7) ? tr_y[i] - 7 : 7 - tr_y[i]);
        if (d < best) best = d;
        if (d == 0 && reached == 0) begin
          reached = 1;
          rs = step;
        end
      end
      if (i == tr_x.size() - 1) la = (tr_alive[i] != 0 && dead == 0) ? 1 : 0;
      if (tr_alive[i] == 0) dead = 1;
      if (step < smax) step++;
    end
    base = (reached != 0) ? (1 << (score_w - 1)) + smax - rs : 30 - best;
    s = base + ((bonus_en != 0 && la != 0) ? 16 : 0);
    if (s > (1 << score_w) - 1) s = (1 << score_w) - 1;
    return s;
  endfunction

  task automatic add_sample(input int x, input int y, input int alive);
    tr_x.push_back(x);
    tr_y.push_back(y);
    tr_alive.push_back(alive);
  endtask

  task automatic clear_trace();
    tr_x.delete();
    tr_y.delete();
    tr_alive.delete();
  endtask

  task automatic drive_start(input string tag);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check_val({tag, "_busy"}, busy_a, 1);
    check_val({tag, "_pos_ready"}, pos_ready_a, 1);
  endtask

  // Sends tr_* with random idle gaps; ends on the negedge after the final
  // acceptance edge. with_last marks the final sample as pos_last.
  task automatic send_samples(input string tag, input bit with_last);
    for (int i = 0; i < tr_x.size(); i++) begin
      if ($urandom_range(0, 1) == 1) begin
        pos_valid = 1'b0;
        @(negedge clk);
        check_val({tag, "_busy_gap"}, busy_a, 1);
      end
      pos_valid = 1'b1;
      pos_x     = 4'(tr_x[i]);
      pos_y     = 4'(tr_y[i]);
      pos_alive = tr_alive[i][0];
      pos_last  = with_last && (i == tr_x.size() - 1);
      @(negedge clk);
    end
    pos_valid = 1'b0;
    pos_last  = 1'b0;
  endtask

  // Full run: push expectations, drive, then pop and compare on output.
  task automatic run_trace(input string tag, input int hold_cycles);
    logic [9:0] ea;
    logic [6:0] eb;
    int waited;
    exp_q_a.push_back(10'(model(6, 10, 0)));
    exp_q_b.push_back(7'(model(5, 7, 1)));
    score_ready = (hold_cycles == 0);
    drive_start(tag);
    send_samples(tag, 1'b1);
    // Negedge after the acceptance edge: in SCORE, nothing presented yet.
    check_val({tag, "_valid_early"}, score_valid_a, 0);
    check_val({tag, "_pos_ready_off"}, pos_ready_a, 0);
    @(negedge clk);
    check_val({tag, "_valid_latency"}, score_valid_a, 1);
    waited = 0;
    while (!score_valid_a && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!score_valid_a) begin
      check_val({tag, "_timeout"}, 0, 1);
      return;
    end
    if (exp_q_a.size() == 0 || exp_q_b.size() == 0) begin
      check_val({tag, "_sb_empty"}, 0, 1);
      return;
    end
    ea = exp_q_a.pop_front();
    eb = exp_q_b.pop_front();
    check_val({tag, "_score_a"}, score_a, ea);
    check_val({tag, "_valid_b"}, score_valid_b, 1);
    check_val({tag, "_score_b"}, score_b, eb);
    for (int c = 0; c < hold_cycles; c++) begin
      start = 1'b1;
      pos_valid = 1'b1;
      @(negedge clk);
      check_val({tag, "_hold_valid"}, score_valid_a, 1);
      check_val({tag, "_hold_score"}, score_a, ea);
      check_val({tag, "_hold_pos_ready"}, pos_ready_a, 0);
      check_val({tag, "_hold_busy"}, busy_a, 1);
    end
    start = 1'b0;
    pos_valid = 1'b0;
    score_ready = 1'b1;
    @(negedge clk);
    check_val({tag, "_valid_drop"}, score_valid_a, 0);
    check_val({tag, "_idle_busy"}, busy_a, 0);
    check_val({tag, "_score_held"}, score_a, ea);
    check_val({tag, "_idle_b"}, busy_b, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pos_ready"}, pos_ready_a, 0);
    check_val({tag, "_score_valid"}, score_valid_a, 0);
    check_val({tag, "_score"}, score_a, 0);
    check_val({tag, "_busy"}, busy_a, 0);
    check_val({tag, "_score_b"}, score_b, 0);
    check_val({tag, "_busy_b"}, busy_b, 0);
  endtask

  // Stimulus sequence and final report.
  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    // pos_valid while idle must not start anything.
    pos_valid = 1'b1;
    @(negedge clk);
    pos_valid = 1'b0;
    check_val("idle_no_accept", busy_a, 0);

    // Best distance only.
    clear_trace();
    add_sample(0, 0, 1); add_sample(3, 4, 1); add_sample(5, 5, 1);
    run_trace("dist", 0);

    // Goal reached at step 2.
    clear_trace();
    add_sample(0, 0, 1); add_sample(7, 6, 1); add_sample(7, 7, 1); add_sample(2, 2, 1);
    run_trace("reach", 0);

    // Goal samples after death are ignored.
    clear_trace();
    add_sample(6, 6, 1); add_sample(7, 7, 0); add_sample(7, 7, 0);
    run_trace("dead", 0);

    // Consumer stalls; start and pos_valid must be ignored in HOLD.
    clear_trace();
    add_sample(0, 0, 1); add_sample(3, 4, 1); add_sample(5, 5, 1);
    run_trace("stall", 5);

    // Reset mid-run after the goal was seen, then a fresh single-sample run.
    clear_trace();
    add_sample(0, 0, 1); add_sample(7, 7, 1);
    drive_start("abort");
    send_samples("abort", 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    clear_trace();
    add_sample(1, 1, 1);
    run_trace("fresh", 0);

    // Every sample dead.
    clear_trace();
    add_sample(7, 7, 0); add_sample(0, 0, 0);
    run_trace("all_dead", 0);

    // Coordinates beyond the goal.
    clear_trace();
    add_sample(15, 15, 1); add_sample(9, 12, 1);
    run_trace("beyond", 0);

    // Goal reached late enough that the narrow step counter saturates.
    clear_trace();
    for (int i = 0; i < 40; i++) begin
      if (i == 35) add_sample(7, 7, 1);
      else add_sample(0, 0, 1);
    end
    run_trace("step_sat", 0);

    // Random traces.
    for (int t = 0; t < 6; t++) begin
      clear_trace();
      for (int i = 0; i < $urandom_range(1, 12); i++)
        add_sample($urandom_range(0, 15), $urandom_range(0, 15), ($urandom_range(0, 7) != 0) ? 1 : 0);
      run_trace("random", 0);
    end

    check_val("sb_drained_a", exp_q_a.size(), 0);
    check_val("sb_drained_b", exp_q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
